// File: rtl/shift_sequencer.sv
// Multi-pass controller for an external 8-bit right shifter: splits a 0..255
// shift amount into passes of at most MAX_STEP positions and feeds results back.
module shift_sequencer #(
  parameter int unsigned MAX_STEP = 7
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       START,
  input  logic [1:0] MODE,
  input  logic [7:0] AMOUNT,
  input  logic [7:0] DATA_IN,
  output logic       BUSY,
  output logic       DONE,
  output logic [7:0] RESULT,
  output logic       SH_A,
  output logic       SH_C,
  output logic [2:0] SH_S,
  output logic [7:0] SH_DATA,
  input  logic [7:0] SH_OUT
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam logic [1:0] MODE_ARITH = 2'b01;
  localparam logic [1:0] MODE_ROT   = 2'b11;
  localparam logic [2:0] STEP_LIM   = 3'(MAX_STEP);

  state_e     state_q, state_d;
  logic [7:0] acc_q, acc_d;
  logic [3:0] rem_q, rem_d;
  logic [1:0] mode_q, mode_d;
  logic [7:0] result_q, result_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;

  logic [2:0] step_s;
  logic [3:0] rem_after_s;
  logic [3:0] load_rem_s;

  // Per-pass step and the pass count loaded at START (rotate wraps, shifts clamp at 8).
  always_comb begin
    if (rem_q > {1'b0, STEP_LIM}) begin
      step_s = STEP_LIM;
    end else begin
      step_s = rem_q[2:0];
    end
    rem_after_s = rem_q - {1'b0, step_s};
    if (MODE == MODE_ROT) begin
      load_rem_s = {1'b0, AMOUNT[2:0]};
    end else if (AMOUNT > 8'd8) begin
      load_rem_s = 4'd8;
    end else begin
      load_rem_s = AMOUNT[3:0];
    end
  end

  // Next-state logic; RESULT is only updated on the edge entering DONE.
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    rem_d    = rem_q;
    mode_d   = mode_q;
    result_d = result_q;
    case (state_q)
      ST_IDLE: begin
        if (START) begin
          acc_d   = DATA_IN;
          mode_d  = MODE;
          rem_d   = load_rem_s;
          state_d = ST_SHIFT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        acc_d = SH_OUT;
        rem_d = rem_after_s;
        if (rem_after_s == 4'd0) begin
          result_d = SH_OUT;
          state_d  = ST_DONE;
        end else begin
          state_d = ST_SHIFT;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d == ST_SHIFT);
    done_d = (state_d == ST_DONE);
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= ST_IDLE;
      acc_q    <= 8'h00;
      rem_q    <= 4'd0;
      mode_q   <= 2'b00;
      result_q <= 8'h00;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      rem_q    <= rem_d;
      mode_q   <= mode_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // Shifter controls: only SHIFT passes a non-zero amount; A=0,C=1 is never produced.
  always_comb begin
    SH_A    = 1'b0;
    SH_C    = 1'b0;
    SH_S    = 3'd0;
    SH_DATA = acc_q;
    if (state_q == ST_SHIFT) begin
      SH_A = (mode_q == MODE_ARITH) || (mode_q == MODE_ROT);
      SH_C = (mode_q == MODE_ROT);
      SH_S = step_s;
    end else begin
      SH_A = 1'b0;
      SH_C = 1'b0;
      SH_S = 3'd0;
    end
  end

  assign BUSY   = busy_q;
  assign DONE   = done_q;
  assign RESULT = result_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Bench for shift_sequencer: directed vector table, reset-abort sequence and
// randomized operations against an arithmetic reference model.
module tb_shift_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       start_r;
  bit         sel_r;
  logic [1:0] mode_r;
  logic [7:0] amt_r;
  logic [7:0] data_r;

  logic       busy7, done7, a7, c7;
  logic [2:0] s7;
  logic [7:0] res7, shd7, sho7;
  logic       busy1, done1, a1, c1;
  logic [2:0] s1;
  logic [7:0] res1, shd1, sho1;

  logic       o_busy, o_done, o_a, o_c;
  logic [2:0] o_s;
  logic [7:0] o_res;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // Environment model of the RIGHTSHIFTER datapath.
  function automatic logic [7:0] shifter_model(input logic a, input logic c,
                                               input logic [2:0] s, input logic [7:0] d);
    logic [15:0] w;
    if (!a) return d >> s;
    else if (!c) return 8'($signed(d) >>> s);
    else begin
      w = {d, d} >> s;
      return w[7:0];
    end
  endfunction

  // Reference: final value of a whole operation, computed in one step.
  function automatic logic [7:0] ref_result(input logic [1:0] m, input logic [7:0] amt,
                                            input logic [7:0] d);
    int k;
    logic [15:0] w;
    case (m)
      2'b11: begin
        k = int'(amt) % 8;
        w = {d, d} >> k;
        return w[7:0];
      end
      2'b01: begin
        if (amt >= 8'd8) return {8{d[7]}};
        else return 8'($signed(d) >>> amt);
      end
      default: begin
        if (amt >= 8'd8) return 8'h00;
        else return d >> amt;
      end
    endcase
  endfunction

  function automatic int ref_total(input logic [1:0] m, input logic [7:0] amt);
    if (m == 2'b11) return int'(amt) % 8;
    else if (amt > 8'd8) return 8;
    else return int'(amt);
  endfunction

  function automatic int ref_passes(input logic [1:0] m, input logic [7:0] amt, input int mx);
    int r;
    r = ref_total(m, amt);
    if (r == 0) return 1;
    else return (r + mx - 1) / mx;
  endfunction

  assign sho7 = shifter_model(a7, c7, s7, shd7);
  assign sho1 = shifter_model(a1, c1, s1, shd1);

  shift_sequencer #(.MAX_STEP(7)) dut7 (
    .CLK(clk), .RESET(reset), .START(start_r & ~sel_r), .MODE(mode_r), .AMOUNT(amt_r),
    .DATA_IN(data_r), .BUSY(busy7), .DONE(done7), .RESULT(res7), .SH_A(a7), .SH_C(c7),
    .SH_S(s7), .SH_DATA(shd7), .SH_OUT(sho7)
  );

  shift_sequencer #(.MAX_STEP(1)) dut1 (
    .CLK(clk), .RESET(reset), .START(start_r & sel_r), .MODE(mode_r), .AMOUNT(amt_r),
    .DATA_IN(data_r), .BUSY(busy1), .DONE(done1), .RESULT(res1), .SH_A(a1), .SH_C(c1),
    .SH_S(s1), .SH_DATA(shd1), .SH_OUT(sho1)
  );

  assign o_busy = sel_r ? busy1 : busy7;
  assign o_done = sel_r ? done1 : done7;
  assign o_a    = sel_r ? a1 : a7;
  assign o_c    = sel_r ? c1 : c7;
  assign o_s    = sel_r ? s1 : s7;
  assign o_res  = sel_r ? res1 : res7;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One complete operation; inputs are scrambled while busy and START is held in DONE.
  task automatic run_op(input string nm, input bit sel, input logic [1:0] m,
                        input logic [7:0] amt, input logic [7:0] d,
                        input logic [7:0] exp_res, input int exp_n);
    int mx, rem, step, edges;
    logic exp_a, exp_c;
    mx    = sel ? 1 : 7;
    rem   = ref_total(m, amt);
    exp_a = (m == 2'b01) || (m == 2'b11);
    exp_c = (m == 2'b11);
    sel_r  = sel;
    mode_r = m;
    amt_r  = amt;
    data_r = d;
    start_r = 1'b1;
    @(posedge clk); #1;
    edges = 0;
    while (o_done !== 1'b1 && edges < 40) begin
      start_r = 1'($urandom_range(0, 1));
      mode_r  = 2'($urandom);
      amt_r   = 8'($urandom);
      data_r  = 8'($urandom);
      step = (rem > mx) ? mx : rem;
      rem  = rem - step;
      chk({nm, " busy"}, {31'd0, o_busy}, 32'd1);
      chk({nm, " sh_s"}, {29'd0, o_s}, step);
      chk({nm, " sh_a"}, {31'd0, o_a}, {31'd0, exp_a});
      chk({nm, " sh_c"}, {31'd0, o_c}, {31'd0, exp_c});
      @(posedge clk); #1;
      edges++;
    end
    chk({nm, " passes"}, edges, exp_n);
    chk({nm, " result"}, {24'd0, o_res}, {24'd0, exp_res});
    chk({nm, " busy_in_done"}, {31'd0, o_busy}, 32'd0);
    chk({nm, " sh_s_in_done"}, {29'd0, o_s}, 32'd0);
    start_r = 1'b1;
    data_r  = ~d;
    @(posedge clk); #1;
    chk({nm, " done_one_cycle"}, {31'd0, o_done}, 32'd0);
    chk({nm, " busy_after"}, {31'd0, o_busy}, 32'd0);
    chk({nm, " result_hold"}, {24'd0, o_res}, {24'd0, exp_res});
    start_r = 1'b0;
  endtask

  typedef struct {
    string      nm;
    bit         sel;
    logic [1:0] mode;
    logic [7:0] amt;
    logic [7:0] data;
    logic [7:0] res;
    int         n;
  } vec_t;

  vec_t vecs[11];

  initial begin
    logic [1:0] m;
    logic [7:0] a, d;
    bit         s;
    vecs[0]  = '{"log3",     1'b0, 2'b00, 8'd3,   8'h96, 8'h12, 1};
    vecs[1]  = '{"ari10",    1'b0, 2'b01, 8'd10,  8'h96, 8'hFF, 2};
    vecs[2]  = '{"ari10pos", 1'b0, 2'b01, 8'd10,  8'h76, 8'h00, 2};
    vecs[3]  = '{"rot13",    1'b0, 2'b11, 8'd13,  8'h51, 8'h8A, 1};
    vecs[4]  = '{"rot8",     1'b0, 2'b11, 8'd8,   8'h51, 8'h51, 1};
    vecs[5]  = '{"m1log7",   1'b1, 2'b00, 8'd7,   8'h80, 8'h01, 7};
    vecs[6]  = '{"m1zero",   1'b1, 2'b00, 8'd0,   8'h5A, 8'h5A, 1};
    vecs[7]  = '{"rsvd2",    1'b0, 2'b10, 8'd2,   8'hF0, 8'h3C, 1};
    vecs[8]  = '{"log255",   1'b0, 2'b00, 8'd255, 8'hFF, 8'h00, 2};
    vecs[9]  = '{"m1rot15",  1'b1, 2'b11, 8'd15,  8'h01, 8'h02, 7};
    vecs[10] = '{"ari8",     1'b0, 2'b01, 8'd8,   8'h80, 8'hFF, 2};

    reset = 1'b1; start_r = 1'b0; sel_r = 1'b0;
    mode_r = 2'b00; amt_r = 8'd0; data_r = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst result7", {24'd0, res7}, 32'd0);
    chk("rst busy7",   {31'd0, busy7}, 32'd0);
    chk("rst done7",   {31'd0, done7}, 32'd0);
    chk("rst sh_s7",   {29'd0, s7}, 32'd0);
    chk("rst sh_data7", {24'd0, shd7}, 32'd0);
    chk("rst result1", {24'd0, res1}, 32'd0);
    chk("rst busy1",   {31'd0, busy1}, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 11; i++) begin
      run_op(vecs[i].nm, vecs[i].sel, vecs[i].mode, vecs[i].amt, vecs[i].data,
             vecs[i].res, vecs[i].n);
    end

    // Reset during the second pass of an arithmetic clamp operation.
    run_op("pre_rst", 1'b0, 2'b00, 8'd3, 8'h96, 8'h12, 1);
    sel_r = 1'b0; mode_r = 2'b01; amt_r = 8'd10; data_r = 8'h96; start_r = 1'b1;
    @(posedge clk); #1;
    start_r = 1'b0;
    chk("abort pass1 busy", {31'd0, busy7}, 32'd1);
    chk("abort pass1 sh_s", {29'd0, s7}, 32'd7);
    @(posedge clk); #1;
    chk("abort pass2 sh_s", {29'd0, s7}, 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("abort busy",   {31'd0, busy7}, 32'd0);
    chk("abort done",   {31'd0, done7}, 32'd0);
    chk("abort result", {24'd0, res7}, 32'd0);
    chk("abort sh_s",   {29'd0, s7}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("abort no_done", {31'd0, done7}, 32'd0);
    end
    run_op("post_rst", 1'b0, 2'b01, 8'd10, 8'h96, 8'hFF, 2);

    for (int i = 0; i < 60; i++) begin
      s = 1'($urandom_range(0, 1));
      m = 2'($urandom);
      a = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 20));
      d = 8'($urandom);
      run_op("rnd", s, m, a, d, ref_result(m, a, d), ref_passes(m, a, s ? 1 : 7));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
